// File: rtl/spram_arbiter_pkg.sv
// Shared types and helpers for the SPRAM arbiter: grant owner encoding and
// byte-enable to nibble-mask expansion.
package spram_arbiter_pkg;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_FETCH = 2'd1,
    GNT_DATA  = 2'd2,
    GNT_LOAD  = 2'd3
  } gnt_e;

  localparam logic [7:0] MASK_ALL = 8'hFF;

  // The SPRAM write mask works on nibbles, so each byte lane owns two bits.
  function automatic logic [7:0] nibble_mask(input logic [3:0] be);
    nibble_mask = '0;
    for (int i = 0; i < 4; i++) nibble_mask[2*i +: 2] = {2{be[i]}};
  endfunction

endpackage

// File: rtl/spram_be_expand.sv
// Combinational byte-enable to SPRAM nibble write-mask expansion.
import spram_arbiter_pkg::*;

module spram_be_expand (
  input  logic [3:0] be_i,
  output logic [7:0] mask_o
);

  assign mask_o = nibble_mask(be_i);

endmodule

// File: rtl/spram_arbiter.sv
// Three-way arbiter (loader write, core data, core fetch) in front of one
// single-ported 32-bit SPRAM bank; one access per cycle, 1-cycle read latency.
import spram_arbiter_pkg::*;

module spram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  im_req,
  input  logic [31:0]           im_addr,
  output logic [31:0]           im_rdata,
  output logic                  im_valid,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [31:0]           dm_addr,
  input  logic [31:0]           dm_wdata,
  input  logic [3:0]            dm_be,
  output logic [31:0]           dm_rdata,
  output logic                  dm_valid,
  input  logic                  ld_req,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [31:0]           ld_wdata,
  output logic                  ld_ack,
  output logic                  core_stall,
  output logic                  addr_err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [7:0]            mem_maskwe,
  input  logic [31:0]           mem_rdata
);

  gnt_e                  gnt;
  gnt_e                  owner_q, owner_d;
  logic                  fair_q, fair_d;
  logic                  err_q, err_d;
  logic                  store_q, store_d;
  logic [31:0]           dm_hold_q, dm_hold_d;
  logic                  im_err, dm_err, dm_store;
  logic [ADDR_WIDTH-1:0] im_word, dm_word;
  logic [7:0]            dm_mask;

  // Any set bit above the bank's byte-address range is an access error.
  assign im_err   = |im_addr[31:ADDR_WIDTH+2];
  assign dm_err   = |dm_addr[31:ADDR_WIDTH+2];
  assign im_word  = im_addr[ADDR_WIDTH+1:2];
  assign dm_word  = dm_addr[ADDR_WIDTH+1:2];
  assign dm_store = dm_we && (dm_be != 4'd0);

  spram_be_expand u_be_expand (
    .be_i   (dm_be),
    .mask_o (dm_mask)
  );

  always_comb begin
    gnt = GNT_NONE;
    if (ld_req)
      gnt = GNT_LOAD;
    else if (dm_req && im_req)
      gnt = (FAIR && fair_q) ? GNT_FETCH : GNT_DATA;
    else if (dm_req)
      gnt = GNT_DATA;
    else if (im_req)
      gnt = GNT_FETCH;
  end

  assign core_stall = (im_req && (gnt != GNT_FETCH)) ||
                      (dm_req && (gnt != GNT_DATA));

  // Issue stage: an out-of-range core request still wins its slot but never
  // reaches the SPRAM; the error is reported with the completion pulse.
  always_comb begin
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_maskwe = '0;
    err_d      = 1'b0;
    store_d    = 1'b0;
    owner_d    = gnt;
    fair_d     = (gnt == GNT_DATA);
    unique case (gnt)
      GNT_LOAD: begin
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = ld_addr;
        mem_wdata  = ld_wdata;
        mem_maskwe = MASK_ALL;
      end
      GNT_DATA: begin
        err_d   = dm_err;
        store_d = dm_store;
        if (!dm_err) begin
          mem_cs   = 1'b1;
          mem_addr = dm_word;
          if (dm_store) begin
            mem_we     = 1'b1;
            mem_wdata  = dm_wdata;
            mem_maskwe = dm_mask;
          end
        end
      end
      GNT_FETCH: begin
        err_d = im_err;
        if (!im_err) begin
          mem_cs   = 1'b1;
          mem_addr = im_word;
        end
      end
      default: ;
    endcase
  end

  // Completion stage, driven by what was issued last cycle.
  always_comb begin
    im_valid  = (owner_q == GNT_FETCH);
    dm_valid  = (owner_q == GNT_DATA);
    ld_ack    = (owner_q == GNT_LOAD);
    addr_err  = err_q;
    im_rdata  = (im_valid && !err_q) ? mem_rdata : '0;
    dm_rdata  = dm_hold_q;
    if (dm_valid) begin
      if (err_q)
        dm_rdata = '0;
      else if (!store_q)
        dm_rdata = mem_rdata;
    end
    dm_hold_d = dm_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= GNT_NONE;
      fair_q    <= 1'b0;
      err_q     <= 1'b0;
      store_q   <= 1'b0;
      dm_hold_q <= '0;
    end else begin
      owner_q   <= owner_d;
      fair_q    <= fair_d;
      err_q     <= err_d;
      store_q   <= store_d;
      dm_hold_q <= dm_hold_d;
    end
  end

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomised scoreboard bench for spram_arbiter with a behavioural SPRAM and
// a request-level reference model of arbitration and memory contents.
module tb_spram_arbiter;

  localparam int AW    = 14;
  localparam bit FAIR  = 1'b1;
  localparam int WORDS = 1 << AW;
  localparam int G_NONE = 0, G_FE = 1, G_DT = 2, G_LD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          im_req, dm_req, dm_we, ld_req;
  logic [31:0]   im_addr, dm_addr, dm_wdata, ld_wdata;
  logic [3:0]    dm_be;
  logic [AW-1:0] ld_addr;
  logic [31:0]   im_rdata, dm_rdata, mem_wdata;
  logic          im_valid, dm_valid, ld_ack, core_stall, addr_err;
  logic          mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_maskwe;
  logic [31:0]   mem_rdata;

  spram_arbiter #(.ADDR_WIDTH(AW), .FAIR(FAIR)) dut (
    .clk(clk), .reset(reset),
    .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_valid(im_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .core_stall(core_stall), .addr_err(addr_err),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_maskwe(mem_maskwe), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural SPRAM macro: nibble-masked write, registered read.
  logic [31:0] mem_arr [0:WORDS-1];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int n = 0; n < 8; n++)
          if (mem_maskwe[n]) mem_arr[mem_addr][4*n +: 4] <= mem_wdata[4*n +: 4];
      end else begin
        mem_rdata <= mem_arr[mem_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; logic [31:0] data; bit err;} exp_t;
  exp_t im_q[$], dm_q[$], ld_q[$];

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model state.
  logic [31:0] ref_mem [0:WORDS-1];
  logic [31:0] last_dm;
  int          last_g;
  bit          g_im, g_dm, g_ld;

  // Monitor: pops the expected completion whenever a pulse appears, and flags
  // a pulse that is missing on its due cycle.
  always @(negedge clk) begin
    bit   e;
    exp_t x;
    e = 1'b0;
    if (im_valid) begin
      if (im_q.size() == 0) chk("im_valid_spurious", 32'd1, 32'd0);
      else begin
        x = im_q.pop_front();
        chk("im_due", cyc, x.due);
        chk("im_rdata", im_rdata, x.data);
        e |= x.err;
      end
    end else if (im_q.size() > 0 && im_q[0].due <= cyc) begin
      x = im_q.pop_front();
      chk("im_valid_missing", 32'd0, 32'd1);
    end
    if (dm_valid) begin
      if (dm_q.size() == 0) chk("dm_valid_spurious", 32'd1, 32'd0);
      else begin
        x = dm_q.pop_front();
        chk("dm_due", cyc, x.due);
        chk("dm_rdata", dm_rdata, x.data);
        e |= x.err;
      end
    end else if (dm_q.size() > 0 && dm_q[0].due <= cyc) begin
      x = dm_q.pop_front();
      chk("dm_valid_missing", 32'd0, 32'd1);
    end
    if (ld_ack) begin
      if (ld_q.size() == 0) chk("ld_ack_spurious", 32'd1, 32'd0);
      else begin
        x = ld_q.pop_front();
        chk("ld_due", cyc, x.due);
      end
    end else if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
      x = ld_q.pop_front();
      chk("ld_ack_missing", 32'd0, 32'd1);
    end
    chk("addr_err", {31'd0, addr_err}, {31'd0, e});
  end

  // Apply the arbitration rules to the current inputs, check the issue-side
  // outputs, push expected completions, then advance one clock.
  task automatic step();
    int          g, w;
    bit          ie, de, st, exp_stall, exp_cs;
    logic [7:0]  msk;
    exp_t        x;
    #1;
    if (ld_req)                g = G_LD;
    else if (im_req && dm_req) g = (FAIR && last_g == G_DT) ? G_FE : G_DT;
    else if (dm_req)           g = G_DT;
    else if (im_req)           g = G_FE;
    else                       g = G_NONE;
    ie = (im_addr >> (AW + 2)) != 0;
    de = (dm_addr >> (AW + 2)) != 0;
    st = dm_we && (dm_be != 4'd0);
    exp_stall = (im_req && g != G_FE) || (dm_req && g != G_DT);
    exp_cs = (g == G_LD) || (g == G_FE && !ie) || (g == G_DT && !de);
    chk("core_stall", {31'd0, core_stall}, {31'd0, exp_stall});
    chk("mem_cs", {31'd0, mem_cs}, {31'd0, exp_cs});
    x.due = cyc + 1;
    x.err = 1'b0;
    x.data = '0;
    case (g)
      G_FE: begin
        w = (im_addr >> 2) % WORDS;
        if (!ie) chk("mem_addr_fe", 32'(mem_addr), w);
        x.err  = ie;
        x.data = ie ? 32'h0 : ref_mem[w];
        im_q.push_back(x);
      end
      G_DT: begin
        w = (dm_addr >> 2) % WORDS;
        if (!de) begin
          chk("mem_addr_dm", 32'(mem_addr), w);
          chk("mem_we_dm", {31'd0, mem_we}, {31'd0, st});
        end
        if (de) last_dm = 32'h0;
        else if (st) begin
          for (int i = 0; i < 4; i++) msk[2*i +: 2] = {2{dm_be[i]}};
          chk("mem_maskwe", {24'd0, mem_maskwe}, {24'd0, msk});
          chk("mem_wdata_dm", mem_wdata, dm_wdata);
          for (int i = 0; i < 4; i++)
            if (dm_be[i]) ref_mem[w][8*i +: 8] = dm_wdata[8*i +: 8];
        end else last_dm = ref_mem[w];
        x.err  = de;
        x.data = last_dm;
        dm_q.push_back(x);
      end
      G_LD: begin
        chk("mem_addr_ld", 32'(mem_addr), 32'(ld_addr));
        chk("mem_we_ld", {31'd0, mem_we}, 32'd1);
        chk("mem_maskwe_ld", {24'd0, mem_maskwe}, 32'hFF);
        ref_mem[ld_addr] = ld_wdata;
        ld_q.push_back(x);
      end
      default: ;
    endcase
    g_im = (g == G_FE);
    g_dm = (g == G_DT);
    g_ld = (g == G_LD);
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    im_req = 0; dm_req = 0; ld_req = 0; dm_we = 0;
    im_addr = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0; ld_addr = 0; ld_wdata = 0;
  endtask

  task automatic chk_zero(input string tag);
    #1;
    chk({tag, "_im_valid"}, {31'd0, im_valid}, 32'd0);
    chk({tag, "_dm_valid"}, {31'd0, dm_valid}, 32'd0);
    chk({tag, "_ld_ack"}, {31'd0, ld_ack}, 32'd0);
    chk({tag, "_addr_err"}, {31'd0, addr_err}, 32'd0);
    chk({tag, "_core_stall"}, {31'd0, core_stall}, 32'd0);
    chk({tag, "_mem_cs"}, {31'd0, mem_cs}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_maskwe"}, {24'd0, mem_maskwe}, 32'd0);
    chk({tag, "_im_rdata"}, im_rdata, 32'd0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) a |= 32'h1 << $urandom_range(AW + 2, 31);
    return a;
  endfunction

  initial begin
    for (int i = 0; i < WORDS; i++) begin mem_arr[i] = '0; ref_mem[i] = '0; end
    mem_rdata = '0;
    last_dm = '0; last_g = G_NONE; g_im = 0; g_dm = 0; g_ld = 0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("post_reset");
    @(posedge clk); #1;

    // Loader preload.
    ld_req = 1;
    ld_addr = 0;  ld_wdata = 32'h11;       step();
    ld_addr = 1;  ld_wdata = 32'h22;       step();
    ld_addr = 2;  ld_wdata = 32'h33;       step();
    ld_addr = 64; ld_wdata = 32'hDEADBEEF; step();
    idle(); step();

    // Back-to-back fetches.
    im_req = 1;
    im_addr = 0; step();
    im_addr = 4; step();
    im_addr = 8; step();
    idle(); step();

    // Simultaneous fetch and data load: data first, fetch next cycle.
    im_req = 1; im_addr = 12; dm_req = 1; dm_addr = 32'h100; step();
    dm_req = 0; step();
    idle(); step();

    // Partial store then load-back.
    dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hAABBCCDD; dm_be = 4'b0110; step();
    dm_we = 0; dm_be = 4'b1111; step();
    idle(); step();

    // Loader starves a pending fetch.
    im_req = 1; im_addr = 16; ld_req = 1;
    for (int i = 0; i < 4; i++) begin ld_addr = AW'(100 + i); ld_wdata = 32'hC0DE0000 + i; step(); end
    ld_req = 0; step();
    idle(); step();

    // Out-of-range data load.
    dm_req = 1; dm_addr = 32'h0001_0000; step();
    idle(); step();

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      if (g_im || !im_req) begin
        im_req = ($urandom_range(0, 9) < 7); im_addr = rnd_addr();
      end
      if (g_dm || !dm_req) begin
        dm_req = ($urandom_range(0, 9) < 6); dm_we = $urandom_range(0, 1);
        dm_addr = rnd_addr(); dm_wdata = $urandom; dm_be = 4'($urandom_range(0, 15));
      end
      if (g_ld || !ld_req) begin
        ld_req = ($urandom_range(0, 19) == 0);
        ld_addr = AW'($urandom_range(0, 63)); ld_wdata = $urandom;
      end
      step();
    end
    idle(); step(); step();

    // Reset arrives in the cycle a fetch is issued.
    im_req = 1; im_addr = 4; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; idle();
    last_g = G_NONE; last_dm = '0;
    chk_zero("reset_mid_fetch");
    @(posedge clk); #1;
    repeat (3) step();

    chk("im_q_drained", im_q.size(), 32'd0);
    chk("dm_q_drained", dm_q.size(), 32'd0);
    chk("ld_q_drained", ld_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
